power_scheduler: RTL and testbench

- Shares the ship's single power reserve among four life-support/command consumers: shield, O2, thermal and propulsion.
- Each consumer requests a fixed-cost power draw. The block grants at most one draw per arbitration round, deducts the cost from a reserve counter, and recharges the reserve from the charge line.
- Emergencies (attack, fatal condition) pre-empt round-robin order.
- Sits between the life-support datapath controls and the power bus.

---
 rtl/power_scheduler_pkg.sv | 28 ++
 rtl/power_scheduler_rr_pick.sv | 40 ++++
 rtl/power_scheduler.sv | 158 +++++++++++++++
 tb/tb_power_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/power_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : power_pkg
//  Description : Shared definitions for the power scheduler: requester
//                indices, requester count, FSM state encoding and a small
//                one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package power_pkg;

  localparam int NREQ       = 4;
  localparam int REQ_SHIELD = 0;
  localparam int REQ_O2     = 1;
  localparam int REQ_TEMP   = 2;
  localparam int REQ_PROP   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/power_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational 4-way round-robin picker. Scans the eligible
//                mask starting at the pointer and wrapping 3->0; the first
//                set bit wins.
//  Ports       : elig  [NREQ-1:0] in  - eligible requester mask
//                ptr   [1:0]      in  - scan start position
//                found            out - at least one requester eligible
//                idx   [1:0]      out - winning requester index
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import power_pkg::*;
(
  input  logic [NREQ-1:0] elig,
  input  logic [1:0]      ptr,
  output logic            found,
  output logic [1:0]      idx
);

  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is the last
  // one written and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/power_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : power_scheduler
//  Description : Shares a single power reserve among four consumers
//                (shield, O2, thermal, propulsion). Grants at most one draw
//                per IDLE->GRANT->WAIT round, deducts the draw from the
//                reserve, recharges from the charge line and saturates at
//                MAX_RESERVE. Attack/fatal conditions pre-empt round-robin.
//  Ports       : clk, rst (async, active high)
//                chrg      in  - charge source active
//                atk       in  - under attack, shield priority
//                fatal     in  - fatal condition, O2 priority
//                req  [3:0] in - per-consumer request, held until granted
//                amt  [4*AW-1:0] in - packed draw amounts
//                gnt  [3:0] out - one-hot one-cycle grant pulse
//                gnt_valid out - OR of gnt
//                reserve [N-1:0] out - current reserve
//                brownout out - reserve below LOW_THRESH
//                state [1:0] out - 0 IDLE, 1 GRANT, 2 WAIT
//  Options     : POWER_LEAK_EN - one unit of standby drain per cycle while
//                chrg is low, floored at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module power_scheduler
  import power_pkg::*;
#(
  parameter int N            = 32,
  parameter int AW           = 8,
  parameter int INIT_RESERVE = 500,
  parameter int MAX_RESERVE  = 1000,
  parameter int CHRG_RATE    = 4,
  parameter int LOW_THRESH   = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chrg,
  input  logic                 atk,
  input  logic                 fatal,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   amt,
  output logic [NREQ-1:0]      gnt,
  output logic                 gnt_valid,
  output logic [N-1:0]         reserve,
  output logic                 brownout,
  output logic [1:0]           state
);

  localparam int NW = N + 1;

  state_e            state_q, state_d;
  logic [N-1:0]      reserve_q, reserve_d;
  logic              brownout_q, brownout_d;
  logic [1:0]        rr_q, rr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;

  logic [AW-1:0]     amt_a [NREQ];
  logic [NREQ-1:0]   elig;
  logic              rr_found;
  logic [1:0]        rr_idx;
  logic              win_found;
  logic [1:0]        win_idx;
  logic              win_rr;
  logic              grant_edge;
  logic [NW-1:0]     sum;

  // Unpack amounts and evaluate eligibility (amt = 0 always passes <=).
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      amt_a[i] = amt[i*AW +: AW];
      elig[i]  = req[i] && (N'(amt_a[i]) <= reserve_q);
    end
  end

  rr_pick u_rr_pick (
    .elig  (elig),
    .ptr   (rr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // Priority selection: emergencies bypass brownout, round-robin does not.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_idx;
    win_rr    = 1'b0;
    if (atk && elig[REQ_SHIELD]) begin
      win_found = 1'b1;
      win_idx   = 2'(REQ_SHIELD);
    end else if (fatal && elig[REQ_O2]) begin
      win_found = 1'b1;
      win_idx   = 2'(REQ_O2);
    end else if (!brownout_q && rr_found) begin
      win_found = 1'b1;
      win_idx   = rr_idx;
      win_rr    = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    rr_d       = rr_q;
    grant_edge = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_GRANT;
          gnt_d      = onehot(win_idx);
          grant_edge = 1'b1;
          // Only fair-share grants advance the pointer.
          if (win_rr) rr_d = win_idx + 2'd1;
        end
      end
      ST_GRANT: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Reserve arithmetic at N+1 bits so charge cannot wrap before the clamp.
  always_comb begin
    sum = {1'b0, reserve_q}
        - (grant_edge ? NW'(amt_a[win_idx]) : NW'(0))
        + (chrg       ? NW'(CHRG_RATE)      : NW'(0));
`ifdef POWER_LEAK_EN
    if (!chrg && (sum != '0)) sum = sum - NW'(1);
`else
    sum = sum;
`endif
    if (sum > NW'(MAX_RESERVE)) reserve_d = N'(MAX_RESERVE);
    else                        reserve_d = sum[N-1:0];
    brownout_d = (reserve_d < N'(LOW_THRESH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      reserve_q  <= N'(INIT_RESERVE);
      brownout_q <= (INIT_RESERVE < LOW_THRESH);
      rr_q       <= 2'd0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      reserve_q  <= reserve_d;
      brownout_q <= brownout_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign reserve   = reserve_q;
  assign brownout  = brownout_q;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_power_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_power_scheduler
//  Description : Directed self-checking bench for power_scheduler. Inputs
//                change on the falling edge; outputs are sampled on the
//                falling edge following each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_power_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        chrg, atk, fatal;
  logic [3:0]  req;
  logic [31:0] amt;
  logic [3:0]  gnt;
  logic        gnt_valid;
  logic [31:0] reserve;
  logic        brownout;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  power_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .chrg      (chrg),
    .atk       (atk),
    .fatal     (fatal),
    .req       (req),
    .amt       (amt),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .reserve   (reserve),
    .brownout  (brownout),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Advance until a grant is visible, bounded at 12 cycles; a timeout
  // leaves gnt at zero, which the caller's comparison reports.
  task automatic wait_gnt();
    for (int i = 0; i < 12; i++) begin
      step();
      if (gnt !== 4'b0000) break;
    end
  endtask

  task automatic do_reset();
    chrg = 0; atk = 0; fatal = 0; req = '0; amt = '0;
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    chrg = 0; atk = 0; fatal = 0; req = '0; amt = '0;
    rst = 1;
    step();
    checks++; if (reserve !== 32'd500) begin errors++; $display("FAIL reset_reserve: got %0d expected 500", reserve); end
    checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b/%b expected 0000/0", gnt, gnt_valid); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (brownout !== 1'b0) begin errors++; $display("FAIL reset_brownout: got %b expected 0", brownout); end
    rst = 0;
    chrg = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if (gnt !== 4'b0000 || state !== 2'd0) begin errors++; $display("FAIL idle_charge_cycle%0d: got gnt %b state %0d expected 0000 0", c, gnt, state); end
    end
    checks++; if (reserve !== 32'd540) begin errors++; $display("FAIL idle_charge_reserve: got %0d expected 540", reserve); end
    chrg = 0;
  endtask

  task automatic test_round_robin();
    logic [3:0]  eg;
    logic [1:0]  es;
    logic [31:0] er;
    do_reset();
    amt = {8'd10, 8'd10, 8'd10, 8'd10};
    req = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      step();
      eg = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      es = (c % 3 == 0) ? 2'd1 : ((c % 3 == 1) ? 2'd2 : 2'd0);
      er = 32'd500 - 32'(10 * (c / 3 + 1));
      checks++; if (gnt !== eg || gnt_valid !== (eg != 0)) begin errors++; $display("FAIL rr_gnt_c%0d: got %b/%b expected %b", c, gnt, gnt_valid, eg); end
      checks++; if (state !== es) begin errors++; $display("FAIL rr_state_c%0d: got %0d expected %0d", c, state, es); end
      checks++; if (reserve !== er) begin errors++; $display("FAIL rr_reserve_c%0d: got %0d expected %0d", c, reserve, er); end
    end
    // Withdrawal: dropping requests simply leaves the scheduler idle.
    req = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (gnt !== 4'b0000 || reserve !== 32'd450) begin errors++; $display("FAIL rr_withdraw_c%0d: got gnt %b reserve %0d expected 0000 450", c, gnt, reserve); end
    end
  endtask

  task automatic test_attack_priority();
    do_reset();
    amt = {8'd10, 8'd10, 8'd10, 8'd10};
    req = 4'b0011;
    wait_gnt();
    checks++; if (gnt !== 4'b0001 || reserve !== 32'd490) begin errors++; $display("FAIL atk_setup0: got %b %0d expected 0001 490", gnt, reserve); end
    wait_gnt();
    checks++; if (gnt !== 4'b0010 || reserve !== 32'd480) begin errors++; $display("FAIL atk_setup1: got %b %0d expected 0010 480", gnt, reserve); end
    // Pointer now 2; attack must pull the shield ahead of thermal.
    req = 4'b0101; atk = 1;
    wait_gnt();
    checks++; if (gnt !== 4'b0001 || reserve !== 32'd470) begin errors++; $display("FAIL atk_grant: got %b %0d expected 0001 470", gnt, reserve); end
    // Pointer must still be 2, so thermal beats O2.
    atk = 0; req = 4'b0111;
    wait_gnt();
    checks++; if (gnt !== 4'b0100 || reserve !== 32'd460) begin errors++; $display("FAIL atk_ptr_kept: got %b %0d expected 0100 460", gnt, reserve); end
    req = 4'b0000;
  endtask

  task automatic test_brownout();
    bit any;
    do_reset();
    amt = {8'd10, 8'd230, 8'd30, 8'd10};
    req = 4'b0100;
    wait_gnt();
    checks++; if (gnt !== 4'b0100 || reserve !== 32'd270 || brownout !== 1'b0) begin errors++; $display("FAIL bo_drain0: got %b %0d %b expected 0100 270 0", gnt, reserve, brownout); end
    wait_gnt();
    checks++; if (gnt !== 4'b0100 || reserve !== 32'd40 || brownout !== 1'b1) begin errors++; $display("FAIL bo_drain1: got %b %0d %b expected 0100 40 1", gnt, reserve, brownout); end
    amt = {8'd10, 8'd10, 8'd30, 8'd10};
    req = 4'b1100;
    any = 0;
    for (int c = 0; c < 9; c++) begin
      step();
      if (gnt !== 4'b0000) any = 1;
    end
    checks++; if (any || reserve !== 32'd40 || brownout !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL bo_block: got granted %0d reserve %0d bo %b state %0d expected 0 40 1 0", any, reserve, brownout, state); end
    fatal = 1; req = 4'b1110;
    wait_gnt();
    checks++; if (gnt !== 4'b0010 || reserve !== 32'd10 || brownout !== 1'b1) begin errors++; $display("FAIL bo_fatal: got %b %0d %b expected 0010 10 1", gnt, reserve, brownout); end
    fatal = 0; req = 4'b0001; atk = 1;
    amt = {8'd0, 8'd0, 8'd0, 8'd20};
    any = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (gnt !== 4'b0000) any = 1;
    end
    checks++; if (any || reserve !== 32'd10) begin errors++; $display("FAIL elig_over: got granted %0d reserve %0d expected 0 10", any, reserve); end
    amt = {8'd0, 8'd0, 8'd0, 8'd10};
    wait_gnt();
    checks++; if (gnt !== 4'b0001 || reserve !== 32'd0) begin errors++; $display("FAIL elig_equal: got %b %0d expected 0001 0", gnt, reserve); end
    amt = 32'd0;
    wait_gnt();
    checks++; if (gnt !== 4'b0001 || reserve !== 32'd0) begin errors++; $display("FAIL elig_zero: got %b %0d expected 0001 0", gnt, reserve); end
    atk = 0; req = 4'b0000;
  endtask

  task automatic test_saturation();
    do_reset();
    chrg = 1;
    for (int c = 0; c < 130; c++) step();
    checks++; if (reserve !== 32'd1000 || brownout !== 1'b0) begin errors++; $display("FAIL sat_charge: got %0d %b expected 1000 0", reserve, brownout); end
    chrg = 0;
    amt = {8'd0, 8'd0, 8'd0, 8'd2};
    req = 4'b0001;
    wait_gnt();
    checks++; if (gnt !== 4'b0001 || reserve !== 32'd998) begin errors++; $display("FAIL sat_draw: got %b %0d expected 0001 998", gnt, reserve); end
    req = 4'b0000;
    step();
    step();
    checks++; if (state !== 2'd0 || reserve !== 32'd998) begin errors++; $display("FAIL sat_hold: got state %0d reserve %0d expected 0 998", state, reserve); end
    // Grant and charge on the same edge: 998 - 1 + 4 clamps to 1000.
    amt = {8'd0, 8'd0, 8'd0, 8'd1};
    req = 4'b0001; chrg = 1;
    step();
    checks++; if (gnt !== 4'b0001 || reserve !== 32'd1000) begin errors++; $display("FAIL sat_clamp: got %b %0d expected 0001 1000", gnt, reserve); end
    chrg = 0; req = 4'b0000;
    step();
    checks++; if (reserve !== 32'd1000) begin errors++; $display("FAIL sat_post: got %0d expected 1000", reserve); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    amt = {8'd0, 8'd0, 8'd0, 8'd10};
    req = 4'b0001;
    wait_gnt();
    checks++; if (gnt !== 4'b0001 || state !== 2'd1 || reserve !== 32'd490) begin errors++; $display("FAIL rstmid_pre: got %b %0d %0d expected 0001 1 490", gnt, state, reserve); end
    #1 rst = 1;
    #1;
    checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_gnt: got %b/%b expected 0000/0", gnt, gnt_valid); end
    checks++; if (reserve !== 32'd500 || state !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d %0d expected 500 0", reserve, state); end
    req = 4'b0000;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1; chrg = 0; atk = 0; fatal = 0; req = '0; amt = '0;
    test_reset();
    test_round_robin();
    test_attack_priority();
    test_brownout();
    test_saturation();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
